// File: rtl/i2c_slv_pkg.sv
// Shared types and constants for the I2C target responder.
// Imported by i2c_slv_sync_filter and i2c_slave_responder.
package i2c_slv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK
    } i2c_slv_state_t;

    typedef enum logic {
        I2C_WR = 1'b0,
        I2C_RD = 1'b1
    } i2c_rw_t;

    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 3;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    endfunction

endpackage

// File: rtl/i2c_slv_sync_filter.sv
// Bus-line synchronizer with level and edge pulses.
// I2C_SLV_GLITCH_FILTER_EN adds a 3-sample majority filter.
module i2c_slv_sync_filter
    import i2c_slv_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;
    logic                   lvl_q;

    // Idle bus level is high, so reset the whole chain to 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [FILT_LEN-1:0] win_q;
    logic                filt_q;

    // Output holds its level until two of three samples disagree.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_q  <= '1;
            filt_q <= 1'b1;
        end else begin
            win_q  <= {win_q[FILT_LEN-2:0], sync_q[SYNC_STAGES-1]};
            filt_q <= maj3(win_q);
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lvl_q <= 1'b1;
        end else begin
            lvl_q <= lvl;
        end
    end

    assign level_o = lvl;
    assign rise_o  = lvl & ~lvl_q;
    assign fall_o  = ~lvl & lvl_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target with a pointer-addressed register file (EEPROM style).
// Optional glitch filter: define I2C_SLV_GLITCH_FILTER_EN.
module i2c_slave_responder
    import i2c_slv_pkg::*;
#(
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int DEPTH          = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_o,
    input  logic [I2C_ADDR_WIDTH-1:0] dev_addr_i,
    output logic                      start_o,
    output logic                      stop_o,
    output logic                      wr_strobe_o,
    output logic [$clog2(DEPTH)-1:0]  wr_idx_o,
    output logic [I2C_DATA_WIDTH-1:0] wr_byte_o,
    output logic                      busy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = I2C_DATA_WIDTH;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_slv_sync_filter u_scl (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .din_i   (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_slv_sync_filter u_sda (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .din_i   (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    logic start_det;
    logic stop_det;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_slv_state_t state_q, state_d;
    i2c_rw_t        rw_q, rw_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [DW-1:0]  sh_q, sh_d;
    logic [PW-1:0]  ptr_q, ptr_d, ptr_inc;
    logic           first_q, first_d;
    logic           mack_q, mack_d;
    logic           sda_d;
    logic           busy_d;
    logic           start_d;
    logic           stop_d;
    logic           we;

    logic [DW-1:0]  mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            rw_q    <= I2C_WR;
            cnt_q   <= '0;
            sh_q    <= '0;
            ptr_q   <= '0;
            first_q <= 1'b0;
            mack_q  <= 1'b1;
            sda_o   <= 1'b1;
            busy_o  <= 1'b0;
            start_o <= 1'b0;
            stop_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            ptr_q   <= ptr_d;
            first_q <= first_d;
            mack_q  <= mack_d;
            sda_o   <= sda_d;
            busy_o  <= busy_d;
            start_o <= start_d;
            stop_o  <= stop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_strobe_o <= 1'b0;
            wr_idx_o    <= '0;
            wr_byte_o   <= '0;
        end else begin
            wr_strobe_o <= we;
            if (we) begin
                mem_q[ptr_q] <= sh_q;
                wr_idx_o     <= ptr_q;
                wr_byte_o    <= sh_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        ptr_d   = ptr_q;
        first_d = first_q;
        mack_d  = mack_q;
        sda_d   = sda_o;
        busy_d  = busy_o;
        start_d = 1'b0;
        stop_d  = 1'b0;
        we      = 1'b0;
        ptr_inc = ptr_q + PW'(1);

        if (start_det) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            sda_d   = 1'b1;
            start_d = 1'b1;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
            stop_d  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    sda_d = 1'b1;
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        sh_d  = {sh_q[DW-2:0], sda_lvl};
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (sh_q[DW-1:1] == dev_addr_i) begin
                            state_d = ST_ADDR_ACK;
                            rw_d    = i2c_rw_t'(sh_q[0]);
                            sda_d   = 1'b0;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (rw_q == I2C_RD) begin
                            state_d = ST_RD_BYTE;
                            sh_d    = mem_q[ptr_q];
                            sda_d   = mem_q[ptr_q][DW-1];
                        end else begin
                            state_d = ST_WR_BYTE;
                            first_d = 1'b1;
                            sda_d   = 1'b1;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        sh_d  = {sh_q[DW-2:0], sda_lvl};
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        state_d = ST_WR_ACK;
                        sda_d   = 1'b0;
                        // First byte after the address only moves the pointer.
                        if (first_q) begin
                            ptr_d   = sh_q[PW-1:0];
                            first_d = 1'b0;
                        end else begin
                            we    = 1'b1;
                            ptr_d = ptr_inc;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        state_d = ST_WR_BYTE;
                        cnt_d   = '0;
                        sda_d   = 1'b1;
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_d = ST_RD_ACK;
                            cnt_d   = '0;
                            sda_d   = 1'b1;
                        end else begin
                            sh_d  = {sh_q[DW-2:0], 1'b0};
                            sda_d = sh_q[DW-2];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        mack_d = sda_lvl;
                    end else if (scl_fall) begin
                        ptr_d = ptr_inc;
                        if (!mack_q) begin
                            state_d = ST_RD_BYTE;
                            sh_d    = mem_q[ptr_inc];
                            sda_d   = mem_q[ptr_inc][DW-1];
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            sda_d   = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bus-level master plus a
// register-file reference model, directed and random transfers.
module tb_i2c_slave_responder;

    localparam int T     = 8;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       msda;
    logic       sda_o;
    logic       start_p;
    logic       stop_p;
    logic       wr_strobe;
    logic [3:0] wr_idx;
    logic [7:0] wr_byte;
    logic       busy;
    logic [6:0] dev_addr = 7'h22;
    wire        sda_bus;

    assign sda_bus = msda & sda_o;

    always #5 clk = ~clk;

    i2c_slave_responder dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .scl_i       (scl),
        .sda_i       (sda_bus),
        .sda_o       (sda_o),
        .dev_addr_i  (dev_addr),
        .start_o     (start_p),
        .stop_o      (stop_p),
        .wr_strobe_o (wr_strobe),
        .wr_idx_o    (wr_idx),
        .wr_byte_o   (wr_byte),
        .busy_o      (busy)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  ref_mem [DEPTH];
    int          ref_ptr;
    logic [11:0] exp_q [$];
    logic [7:0]  dq [$];

    logic [11:0] obs_mem [1024];
    int          obs_n   = 0;
    int          obs_rd  = 0;
    int          n_start = 0;
    int          n_stop  = 0;
    int          low_cnt = 0;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1 && obs_n < 1024) begin
            obs_mem[obs_n] <= {wr_idx, wr_byte};
            obs_n <= obs_n + 1;
        end
        if (start_p === 1'b1) n_start <= n_start + 1;
        if (stop_p === 1'b1)  n_stop <= n_stop + 1;
        if (sda_o === 1'b0)   low_cnt <= low_cnt + 1;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b, output logic r);
        msda = b;
        wait_clk(T);
        scl = 1'b1;
        wait_clk(T / 2);
        @(negedge clk);
        r = sda_bus;
        wait_clk(T / 2);
        scl = 1'b0;
        wait_clk(T);
    endtask

    task automatic i2c_start();
        msda = 1'b1;
        wait_clk(T);
        scl = 1'b1;
        wait_clk(T);
        msda = 1'b0;
        wait_clk(T);
        scl = 1'b0;
        wait_clk(T);
    endtask

    task automatic i2c_stop();
        msda = 1'b0;
        wait_clk(T);
        scl = 1'b1;
        wait_clk(T);
        msda = 1'b1;
        wait_clk(T);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) send_bit(b[i], r);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, r);
            d[i] = r;
        end
        send_bit(nack, r);
    endtask

    task automatic check_strobes(input string tag);
        wait_clk(4);
        check({tag, "_nstb"}, 32'(obs_n - obs_rd), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_rd < obs_n) begin
            check({tag, "_stb"}, 32'(obs_mem[obs_rd]),
                  32'(exp_q.pop_front()));
            obs_rd++;
        end
        obs_rd = obs_n;
        exp_q.delete();
    endtask

    task automatic m_write(input logic [7:0] p, input logic [7:0] d[$]);
        logic a;
        i2c_start();
        write_byte(8'h44, a);
        check("wr_addr_ack", 32'(a), 0);
        @(negedge clk);
        check("wr_busy", 32'(busy), 1);
        write_byte(p, a);
        check("wr_ptr_ack", 32'(a), 0);
        ref_ptr = int'(p) % DEPTH;
        foreach (d[i]) begin
            write_byte(d[i], a);
            check("wr_data_ack", 32'(a), 0);
            exp_q.push_back({4'(ref_ptr), d[i]});
            ref_mem[ref_ptr] = d[i];
            ref_ptr = (ref_ptr + 1) % DEPTH;
        end
        i2c_stop();
        check_strobes("wr");
    endtask

    task automatic m_read(input int n, input logic set_ptr,
                          input logic [7:0] p);
        logic       a;
        logic [7:0] d;
        i2c_start();
        if (set_ptr) begin
            write_byte(8'h44, a);
            check("rd_wa_ack", 32'(a), 0);
            write_byte(p, a);
            check("rd_ptr_ack", 32'(a), 0);
            ref_ptr = int'(p) % DEPTH;
            i2c_start();
        end
        write_byte(8'h45, a);
        check("rd_addr_ack", 32'(a), 0);
        for (int i = 0; i < n; i++) begin
            read_byte(d, i == n - 1);
            check("rd_data", 32'(d), 32'(ref_mem[ref_ptr]));
            ref_ptr = (ref_ptr + 1) % DEPTH;
        end
        @(negedge clk);
        check("rd_busy_nack", 32'(busy), 0);
        i2c_stop();
        check_strobes("rd");
    endtask

    task automatic m_mismatch(input logic [6:0] ad, input logic rw);
        logic a;
        int   low0;
        low0 = low_cnt;
        i2c_start();
        write_byte({ad, rw}, a);
        check("mm_nack", 32'(a), 1);
        i2c_stop();
        check("mm_sda_low", 32'(low_cnt - low0), 0);
        check("mm_busy", 32'(busy), 0);
        check_strobes("mm");
    endtask

`ifdef I2C_SLV_GLITCH_FILTER_EN
    task automatic glitch_test();
        logic       a;
        logic [7:0] d;
        d = 8'hC3;
        i2c_start();
        write_byte(8'h44, a);
        write_byte(8'h05, a);
        for (int i = 7; i >= 0; i--) begin
            msda = d[i];
            wait_clk(T / 2);
            if (i == 4) begin
                scl = 1'b1;
                wait_clk(1);
                scl = 1'b0;
            end
            wait_clk(T / 2);
            scl = 1'b1;
            wait_clk(T);
            scl = 1'b0;
            wait_clk(T);
        end
        send_bit(1'b1, a);
        check("glitch_ack", 32'(a), 0);
        i2c_stop();
        exp_q.push_back({4'h5, d});
        ref_mem[5] = d;
        ref_ptr = 6;
        check_strobes("glitch");
    endtask
`endif

    initial begin
        #1_500_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         s0;
        int         p0;
        int         op;
        logic       a;
        logic [7:0] ab;
        logic [6:0] bad_ad;

        rst  = 1'b1;
        scl  = 1'b1;
        msda = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        ref_ptr = 0;
        wait_clk(4);
        @(negedge clk);
        rst = 1'b0;
        wait_clk(4);
        @(negedge clk);
        check("rst_sda", 32'(sda_o), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_stb", 32'(wr_strobe), 0);
        check("rst_start", 32'(start_p), 0);
        check("rst_stop", 32'(stop_p), 0);

        s0 = n_start;
        p0 = n_stop;
        dq = {8'hA5, 8'h5A};
        m_write(8'h03, dq);
        check("wr_nstart", 32'(n_start - s0), 1);
        check("wr_nstop", 32'(n_stop - p0), 1);

        m_read(2, 1'b1, 8'h03);

        dq = {8'h11, 8'h22};
        m_write(8'hFF, dq);
        m_read(2, 1'b1, 8'h0F);

        m_mismatch(7'h23, 1'b0);

        i2c_start();
        write_byte(8'h44, a);
        write_byte(8'h09, a);
        ref_ptr = 9;
        ab = 8'hB7;
        for (int i = 7; i >= 4; i--) send_bit(ab[i], a);
        i2c_stop();
        check("abort_busy", 32'(busy), 0);
        check_strobes("abort");
        m_read(2, 1'b0, 8'h00);

`ifdef I2C_SLV_GLITCH_FILTER_EN
        glitch_test();
        m_read(1, 1'b1, 8'h05);
`endif

        i2c_start();
        ab = 8'h44;
        for (int i = 7; i >= 0; i--) send_bit(ab[i], a);
        msda = 1'b1;
        wait_clk(2);
        @(negedge clk);
        check("rst_ack_low", 32'(sda_o), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_sda_rel", 32'(sda_o), 1);
        check("rst_busy_mid", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        ref_ptr = 0;
        wait_clk(T);
        scl = 1'b1;
        wait_clk(T);
        obs_rd = obs_n;
        m_read(DEPTH, 1'b1, 8'h00);

        for (int k = 0; k < 14; k++) begin
            op = int'($urandom_range(0, 3));
            if (op == 0) begin
                dq.delete();
                for (int j = 0; j < int'($urandom_range(0, 4)); j++)
                    dq.push_back(8'($urandom));
                m_write(8'($urandom), dq);
            end else if (op == 1) begin
                m_read(int'($urandom_range(1, 4)), 1'b1, 8'($urandom));
            end else if (op == 2) begin
                m_read(int'($urandom_range(1, 3)), 1'b0, 8'h00);
            end else begin
                bad_ad = 7'($urandom_range(0, 127));
                if (bad_ad == 7'h22) bad_ad = 7'h23;
                m_mismatch(bad_ad, 1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
